uno_card_pool: RTL and testbench
================================

// Module: uno_card_pool
// PURPOSE
//  Parametrised draw/discard card store for the UNO engine. Holds a draw pile and a discard pile.
//  Fisher-Yates shuffles the draw pile with an LFSR and serves multi-card draws over a valid/ready stream.
//  Auto-recycles the discard pile into the draw pile when it runs dry mid-draw.
//  Sits between the game controller (load/shuffle/draw/discard commands) and the player-hand logic.
// PARAMETERS
//  CARD_W    6    card width: [CARD_W-1:CARD_W-2] colour, rest value
//  DEPTH     128  capacity of each pile (>=108)
//  IDX_W     $clog2(DEPTH+1)  pile count width (derived)
//  LFSR_W    8    LFSR width, >= $clog2(DEPTH)
//  MAX_DRAW  4    largest draw request
// PORTS
//  i_clk           in   1         clock
//  i_rst_n         in   1         asynchronous active-low reset
//  i_clear         in   1         empty both piles (IDLE only)
//  i_load_valid    in   1         push i_load_card onto draw pile (IDLE only)
//  i_load_card     in   CARD_W    card to load
//  i_shuffle       in   1         start shuffle of draw pile (IDLE only)
//  i_draw_req      in   1         request i_draw_cnt cards (IDLE only)
//  i_draw_cnt      in   $clog2(MAX_DRAW+1)  1..MAX_DRAW; 0 ignored, >MAX_DRAW saturates
//  o_card_valid    out  1         o_card is top of draw pile
//  o_card          out  CARD_W    card being drawn
//  i_card_ready    in   1         consumer accepts o_card
//  i_discard_valid in   1         push i_discard_card onto discard pile
//  i_discard_card  in   CARD_W    discarded card
//  o_discard_ready out  1         discard accepted this cycle
//  o_draw_cnt      out  IDX_W     cards in draw pile
//  o_disc_cnt      out  IDX_W     cards in discard pile
//  o_busy          out  1         FSM not IDLE
//  o_short         out  1         1-cycle pulse: draw aborted, both piles empty
// BEHAVIOUR
//  Reset: all piles empty, counts 0; o_card_valid=0, o_busy=0, o_short=0, o_card=0; FSM=IDLE.
//  Reset: LFSR=1, seed counter=0. Reset mid-operation aborts everything; no partial state survives.
//  Seed counter free-runs every cycle; on accepted i_shuffle, LFSR <= counter, or 1 if counter==0.
//  Command priority in IDLE: i_clear > i_load_valid > i_shuffle > i_draw_req. Commands outside IDLE are ignored.
//  Load: written at index o_draw_cnt, count+1 next cycle; ignored when o_draw_cnt==DEPTH.
//  FSM states: IDLE, SHUFFLE, DRAW, RECYCLE.
//  SHUFFLE: i runs from cnt-1 down to 1.
//   - Each cycle the LFSR steps; j = lfsr mod 2^$clog2(DEPTH).
//   - If j>i: reject (no write). Else swap pile[i] and pile[j], then i-1.
//   - Exit to IDLE when i reaches 0, or to DRAW if entered from RECYCLE. cnt<=1 exits after 1 cycle.
//  DRAW: remaining <= i_draw_cnt on entry.
//   - o_card_valid=1 with o_card=pile[cnt-1] while cnt>0.
//   - On valid&ready: cnt-1 and remaining-1; remaining==0 -> IDLE.
//   - o_card is stable while valid&!ready.
//   - cnt==0 with remaining>0: disc_cnt>0 -> RECYCLE; disc_cnt==0 -> pulse o_short, remaining cleared, IDLE.
//  RECYCLE: moves one discard card per cycle (top first) to the draw pile, then SHUFFLE, then DRAW.
//   - o_discard_ready=0 in RECYCLE; otherwise 1 unless o_disc_cnt==DEPTH.
//  Simultaneous discard push and recycle cannot occur (ready low).
//  Simultaneous draw pop and discard push: both take effect the same cycle.
//  Counts never wrap: saturating guards at 0 and DEPTH.
// STRUCTURE
//  Shared package uno_pkg: card_t (CARD_W), colour_e {RED,YELLOW,GREEN,BLUE}.
//  uno_pkg also holds value constants (SKIP=10, REV=11, DRAW2=12, WILD=13, WILD4=14) and the pool_state_e enum.
//  Sub-module uno_lfsr #(LFSR_W): maximal-length Galois LFSR with seed load and step enable; taps table in uno_pkg.
//  Piles are register arrays; no RAM inference is required.
// TESTING
//  1. Load 108 canonical cards, no shuffle, draw 1 -> o_card = last loaded card (blue WILD4 6'h3E); o_draw_cnt 108->107.
//  2. Load 108, shuffle with counter seed 0x5A -> o_busy falls; multiset of pile unchanged (scoreboard); order differs from load order.
//  3. Draw cnt=4 with i_card_ready toggling 1,0,1,0... -> exactly 4 handshakes; o_card stable during stalls; count -4.
//  4. Draw pile=2, discard=10, draw cnt=4 -> 2 cards, RECYCLE (o_discard_ready=0 for 10 cycles), shuffle, 2 more; final counts 8/0.
//  5. Both piles empty, draw cnt=2 -> no o_card_valid; o_short pulses exactly 1 cycle; back to IDLE.
//  6. Assert i_rst_n low mid-SHUFFLE -> counts 0, o_busy=0 immediately; load into full pile (DEPTH) is ignored.

Source files
------------

// File: rtl/uno_pkg.sv
// rtl/uno_pkg.sv - shared UNO card encoding, pool FSM states and LFSR tap table
package uno_pkg;

  localparam int CARD_BITS = 6;

  typedef logic [CARD_BITS-1:0] card_t;

  typedef enum logic [1:0] {RED, YELLOW, GREEN, BLUE} colour_e;

  localparam logic [CARD_BITS-3:0] SKIP  = 4'd10;
  localparam logic [CARD_BITS-3:0] REV   = 4'd11;
  localparam logic [CARD_BITS-3:0] DRAW2 = 4'd12;
  localparam logic [CARD_BITS-3:0] WILD  = 4'd13;
  localparam logic [CARD_BITS-3:0] WILD4 = 4'd14;

  typedef enum logic [1:0] {
    POOL_IDLE,
    POOL_SHUFFLE,
    POOL_DRAW,
    POOL_RECYCLE
  } pool_state_e;

  function automatic card_t mk_card(input colour_e c, input logic [CARD_BITS-3:0] v);
    return {c, v};
  endfunction

  // Right-shift Galois feedback masks giving a maximal-length sequence per width.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/uno_lfsr.sv
// rtl/uno_lfsr.sv - maximal-length Galois LFSR with seed load and step enable
module uno_lfsr
  import uno_pkg::*;
#(
  parameter int LFSR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

  logic [LFSR_W-1:0] state_q, state_d;

  // A zero seed would lock the register, so it is replaced by 1.
  always_comb begin
    state_d = state_q;
    if (i_load) begin
      state_d = (i_seed == '0) ? LFSR_W'(1) : i_seed;
    end else if (i_step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LFSR_W'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/uno_card_pool.sv
// rtl/uno_card_pool.sv - draw/discard card store with LFSR shuffle, streamed draws and auto-recycle
module uno_card_pool
  import uno_pkg::*;
#(
  parameter int CARD_W   = 6,
  parameter int DEPTH    = 128,
  parameter int IDX_W    = $clog2(DEPTH + 1),
  parameter int LFSR_W   = 8,
  parameter int MAX_DRAW = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic                           i_load_valid,
  input  logic [CARD_W-1:0]              i_load_card,
  input  logic                           i_shuffle,
  input  logic                           i_draw_req,
  input  logic [$clog2(MAX_DRAW+1)-1:0]  i_draw_cnt,
  output logic                           o_card_valid,
  output logic [CARD_W-1:0]              o_card,
  input  logic                           i_card_ready,
  input  logic                           i_discard_valid,
  input  logic [CARD_W-1:0]              i_discard_card,
  output logic                           o_discard_ready,
  output logic [IDX_W-1:0]               o_draw_cnt,
  output logic [IDX_W-1:0]               o_disc_cnt,
  output logic                           o_busy,
  output logic                           o_short
);

  localparam int               AW      = $clog2(DEPTH);
  localparam int               DW      = $clog2(MAX_DRAW + 1);
  localparam logic [IDX_W-1:0] FULL    = IDX_W'(DEPTH);
  localparam logic [DW-1:0]    MAX_CNT = DW'(MAX_DRAW);

  logic [CARD_W-1:0] draw_pile_q [DEPTH];
  logic [CARD_W-1:0] disc_pile_q [DEPTH];

  pool_state_e       state_q, state_d;
  logic [IDX_W-1:0]  draw_cnt_q, draw_cnt_d;
  logic [IDX_W-1:0]  disc_cnt_q, disc_cnt_d;
  logic [IDX_W-1:0]  shuf_i_q, shuf_i_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic              from_rec_q, from_rec_d;
  logic [LFSR_W-1:0] seed_cnt_q, seed_cnt_d;

  logic              lfsr_load, lfsr_step;
  logic [LFSR_W-1:0] lfsr_state;
  logic              lfsr_unused;

  logic              wa_en, wb_en, dw_en;
  logic [AW-1:0]     wa_addr, wb_addr, dw_addr;
  logic [CARD_W-1:0] wa_data, wb_data;

  logic [AW-1:0]     draw_top, disc_top, shuf_i_addr, shuf_j;
  logic              card_valid, pop, disc_ready, push, short_pulse;

  uno_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (lfsr_load),
    .i_seed  (seed_cnt_q),
    .i_step  (lfsr_step),
    .o_state (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state;

  assign draw_top    = AW'(draw_cnt_q - 1'b1);
  assign disc_top    = AW'(disc_cnt_q - 1'b1);
  assign shuf_i_addr = AW'(shuf_i_q);
  assign shuf_j      = lfsr_state[AW-1:0];

  assign card_valid  = (state_q == POOL_DRAW) && (draw_cnt_q != '0);
  assign pop         = card_valid && i_card_ready;
  assign disc_ready  = (state_q != POOL_RECYCLE) && (disc_cnt_q != FULL);
  assign push        = i_discard_valid && disc_ready;

  always_comb begin
    seed_cnt_d  = seed_cnt_q + 1'b1;
    state_d     = state_q;
    draw_cnt_d  = draw_cnt_q;
    disc_cnt_d  = disc_cnt_q;
    shuf_i_d    = shuf_i_q;
    rem_d       = rem_q;
    from_rec_d  = from_rec_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    short_pulse = 1'b0;
    wa_en       = 1'b0;
    wa_addr     = AW'(draw_cnt_q);
    wa_data     = i_load_card;
    wb_en       = 1'b0;
    wb_addr     = shuf_j;
    wb_data     = draw_pile_q[shuf_i_addr];
    dw_en       = push;
    dw_addr     = AW'(disc_cnt_q);

    if (push) begin
      disc_cnt_d = disc_cnt_q + 1'b1;
    end

    case (state_q)
      POOL_IDLE: begin
        if (i_clear) begin
          draw_cnt_d = '0;
          disc_cnt_d = '0;
        end else if (i_load_valid) begin
          if (draw_cnt_q != FULL) begin
            wa_en      = 1'b1;
            draw_cnt_d = draw_cnt_q + 1'b1;
          end
        end else if (i_shuffle) begin
          lfsr_load  = 1'b1;
          shuf_i_d   = (draw_cnt_q == '0) ? '0 : draw_cnt_q - 1'b1;
          from_rec_d = 1'b0;
          state_d    = POOL_SHUFFLE;
        end else if (i_draw_req && (i_draw_cnt != '0)) begin
          rem_d   = (i_draw_cnt > MAX_CNT) ? MAX_CNT : i_draw_cnt;
          state_d = POOL_DRAW;
        end
      end

      // Rejection sampling keeps j uniform over 0..i without a modulo divider.
      POOL_SHUFFLE: begin
        lfsr_step = 1'b1;
        if (shuf_i_q == '0) begin
          state_d = from_rec_q ? POOL_DRAW : POOL_IDLE;
        end else if (IDX_W'(shuf_j) <= shuf_i_q) begin
          wa_en    = 1'b1;
          wa_addr  = shuf_i_addr;
          wa_data  = draw_pile_q[shuf_j];
          wb_en    = 1'b1;
          shuf_i_d = shuf_i_q - 1'b1;
          if (shuf_i_q == IDX_W'(1)) begin
            state_d = from_rec_q ? POOL_DRAW : POOL_IDLE;
          end
        end
      end

      POOL_DRAW: begin
        if (draw_cnt_q == '0) begin
          if (disc_cnt_q != '0) begin
            state_d = POOL_RECYCLE;
          end else begin
            short_pulse = 1'b1;
            rem_d       = '0;
            state_d     = POOL_IDLE;
          end
        end else if (pop) begin
          draw_cnt_d = draw_cnt_q - 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == DW'(1)) begin
            state_d = POOL_IDLE;
          end
        end
      end

      // The last card moved hands straight to SHUFFLE so no idle cycle is spent here.
      POOL_RECYCLE: begin
        if ((draw_cnt_q != FULL) && (disc_cnt_q != '0)) begin
          wa_en      = 1'b1;
          wa_data    = disc_pile_q[disc_top];
          draw_cnt_d = draw_cnt_q + 1'b1;
          disc_cnt_d = disc_cnt_q - 1'b1;
          if (disc_cnt_q == IDX_W'(1)) begin
            state_d    = POOL_SHUFFLE;
            shuf_i_d   = draw_cnt_q;
            from_rec_d = 1'b1;
          end
        end else begin
          state_d    = POOL_SHUFFLE;
          shuf_i_d   = (draw_cnt_q == '0) ? '0 : draw_cnt_q - 1'b1;
          from_rec_d = 1'b1;
        end
      end

      default: state_d = POOL_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= POOL_IDLE;
      draw_cnt_q <= '0;
      disc_cnt_q <= '0;
      shuf_i_q   <= '0;
      rem_q      <= '0;
      from_rec_q <= 1'b0;
      seed_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      draw_cnt_q <= draw_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      shuf_i_q   <= shuf_i_d;
      rem_q      <= rem_d;
      from_rec_q <= from_rec_d;
      seed_cnt_q <= seed_cnt_d;
    end
  end

  // Pile contents need no reset: the counts alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (wa_en) draw_pile_q[wa_addr] <= wa_data;
    if (wb_en) draw_pile_q[wb_addr] <= wb_data;
    if (dw_en) disc_pile_q[dw_addr] <= i_discard_card;
  end

  assign o_card_valid    = card_valid;
  assign o_card          = card_valid ? draw_pile_q[draw_top] : '0;
  assign o_discard_ready = disc_ready;
  assign o_draw_cnt      = draw_cnt_q;
  assign o_disc_cnt      = disc_cnt_q;
  assign o_busy          = (state_q != POOL_IDLE);
  assign o_short         = short_pulse;

endmodule

// File: tb/tb_uno_card_pool.sv
// tb/tb_uno_card_pool.sv - scoreboard bench for uno_card_pool with a queue-based pile model
module tb_uno_card_pool;

  localparam int CARD_W   = 6;
  localparam int DEPTH    = 128;
  localparam int IDX_W    = 8;
  localparam int LFSR_W   = 8;
  localparam int MAX_DRAW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_clear, i_load_valid, i_shuffle, i_draw_req;
  logic [CARD_W-1:0] i_load_card, i_discard_card;
  logic [2:0]        i_draw_cnt;
  logic              i_card_ready, i_discard_valid;
  logic              o_card_valid, o_discard_ready, o_busy, o_short;
  logic [CARD_W-1:0] o_card;
  logic [IDX_W-1:0]  o_draw_cnt, o_disc_cnt;

  always #5 clk = ~clk;

  uno_card_pool #(
    .CARD_W(CARD_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LFSR_W(LFSR_W), .MAX_DRAW(MAX_DRAW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear),
    .i_load_valid(i_load_valid), .i_load_card(i_load_card),
    .i_shuffle(i_shuffle), .i_draw_req(i_draw_req), .i_draw_cnt(i_draw_cnt),
    .o_card_valid(o_card_valid), .o_card(o_card), .i_card_ready(i_card_ready),
    .i_discard_valid(i_discard_valid), .i_discard_card(i_discard_card),
    .o_discard_ready(o_discard_ready), .o_draw_cnt(o_draw_cnt), .o_disc_cnt(o_disc_cnt),
    .o_busy(o_busy), .o_short(o_short)
  );

  typedef struct packed {
    logic        wild;
    logic [5:0]  card;
  } exp_t;

  exp_t        exp_q[$];
  logic [5:0]  got_any[$];
  logic [5:0]  mdraw[$];
  logic [5:0]  mdisc[$];
  logic [5:0]  canon[$];
  bit          unord;
  int          checks = 0, errors = 0;
  int          hs_count = 0, short_cycles = 0, valid_cycles = 0, ready_lo = 0;
  int          cyc;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_card;
  exp_t        mon_e;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: handshakes and stall stability sampled half a cycle before the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", int'(o_card_valid), 1);
        chk("stall_card", int'(o_card), int'(prev_card));
      end
      if (o_card_valid && i_card_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_card: got 0x%0h expected no card", o_card);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.wild) got_any.push_back(o_card);
          else if (o_card !== mon_e.card) begin
            errors++;
            $display("FAIL card: got 0x%0h expected 0x%0h", o_card, mon_e.card);
          end
        end
      end
      prev_stall = o_card_valid && !i_card_ready;
      prev_card  = o_card;
      if (o_short) short_cycles++;
      if (o_card_valid) valid_cycles++;
      if (!o_discard_ready) ready_lo++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_clear = 0; i_load_valid = 0; i_shuffle = 0; i_draw_req = 0;
    i_load_card = '0; i_discard_card = '0; i_draw_cnt = '0;
    i_card_ready = 0; i_discard_valid = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    mdraw.delete(); mdisc.delete(); exp_q.delete(); got_any.delete();
    unord = 0;
  endtask

  task automatic load_list(input logic [5:0] cards[$]);
    foreach (cards[k]) begin
      i_load_valid = 1'b1;
      i_load_card  = cards[k];
      step();
      if (mdraw.size() < DEPTH) mdraw.push_back(cards[k]);
    end
    i_load_valid = 1'b0;
  endtask

  task automatic load_random(input int n);
    logic [5:0] q[$];
    for (int k = 0; k < n; k++) q.push_back(6'($urandom));
    load_list(q);
  endtask

  task automatic discard_one(input logic [5:0] c);
    i_discard_valid = 1'b1;
    i_discard_card  = c;
    step();
    if (mdisc.size() < DEPTH) mdisc.push_back(c);
    i_discard_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (o_busy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  // mode 0: ready always high, 1: 1,0,1,0..., 2: random. rand_disc pushes discards mid-draw.
  task automatic draw(input int n, input int mode, input bit rand_disc);
    int         eff, t;
    bit         shorted, tog;
    logic [5:0] x;
    exp_t       e;
    eff = (n == 0) ? 0 : ((n > MAX_DRAW) ? MAX_DRAW : n);
    shorted = 0;
    for (int k = 0; k < eff && !shorted; k++) begin
      if (mdraw.size() == 0 && mdisc.size() != 0) begin
        while (mdisc.size() != 0) mdraw.push_back(mdisc.pop_back());
        unord = 1;
      end
      if (mdraw.size() == 0) shorted = 1;
      else begin
        x = mdraw.pop_back();
        e.wild = unord;
        e.card = x;
        exp_q.push_back(e);
      end
    end
    i_draw_cnt   = n[2:0];
    i_draw_req   = 1'b1;
    i_card_ready = 1'b0;
    step();
    i_draw_req = 1'b0;
    t = 0;
    tog = 1;
    while (o_busy && t < 5000) begin
      case (mode)
        0:       i_card_ready = 1'b1;
        1:       i_card_ready = tog;
        default: i_card_ready = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      if (rand_disc && mdisc.size() < DEPTH - 1 && $urandom_range(0, 3) == 0) begin
        i_discard_valid = 1'b1;
        i_discard_card  = 6'($urandom);
        mdisc.push_back(i_discard_card);
      end else begin
        i_discard_valid = 1'b0;
      end
      step();
      t++;
    end
    i_discard_valid = 1'b0;
    i_card_ready    = 1'b0;
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL draw_timeout: busy still 1 after %0d cycles, required 0", t);
    end
    chk("exp_drained", exp_q.size(), 0);
  endtask

  function automatic int hist_diff(input logic [5:0] a[$], input logic [5:0] b[$]);
    int h[64];
    int d = 0;
    foreach (h[k]) h[k] = 0;
    foreach (a[k]) h[a[k]]++;
    foreach (b[k]) h[b[k]]--;
    foreach (h[k]) if (h[k] != 0) d++;
    return d;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         hs0, rl0, sc0, vc0, diff, g;
    logic [5:0] disc10[$];
    logic [5:0] q[$];

    // canonical deck: per colour one 0, two of 1..DRAW2; then 4 wilds, then 4 wild-draw-fours
    for (int c = 0; c < 4; c++) begin
      canon.push_back(6'(c * 16));
      for (int v = 1; v <= 12; v++) begin
        canon.push_back(6'(c * 16 + v));
        canon.push_back(6'(c * 16 + v));
      end
    end
    for (int c = 0; c < 4; c++) canon.push_back(6'(c * 16 + 13));
    for (int c = 0; c < 4; c++) canon.push_back(6'(c * 16 + 14));

    do_reset();
    chk("rst_draw_cnt", int'(o_draw_cnt), 0);
    chk("rst_disc_cnt", int'(o_disc_cnt), 0);
    chk("rst_valid", int'(o_card_valid), 0);
    chk("rst_card", int'(o_card), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_short", int'(o_short), 0);
    chk("rst_disc_ready", int'(o_discard_ready), 1);

    // unshuffled deck: top card is the last one loaded
    load_list(canon);
    chk("t1_cnt_loaded", int'(o_draw_cnt), 108);
    draw(1, 0, 0);
    chk("t1_cnt_after", int'(o_draw_cnt), 107);

    // shuffle seeded from counter value 0x5A, then drain the whole pile
    do_reset();
    load_list(canon);
    g = 0;
    while ((cyc % 256) != 90 && g < 300) begin
      step();
      g++;
    end
    i_shuffle = 1'b1;
    step();
    i_shuffle = 1'b0;
    unord = 1;
    wait_idle(30000, "t2_shuffle");
    chk("t2_cnt_kept", int'(o_draw_cnt), 108);
    got_any.delete();
    for (int k = 0; k < 27; k++) draw(4, 0, 0);
    chk("t2_drained", int'(o_draw_cnt), 0);
    chk("t2_n_cards", got_any.size(), 108);
    chk("t2_multiset", hist_diff(got_any, canon), 0);
    diff = 0;
    foreach (got_any[k]) if (k < 108 && got_any[k] !== canon[107 - k]) diff++;
    chk("t2_order_differs", int'(diff > 0), 1);

    // draw of 4 against a toggling consumer
    do_reset();
    load_random(20);
    hs0 = hs_count;
    draw(4, 1, 0);
    chk("t3_handshakes", hs_count - hs0, 4);
    chk("t3_cnt", int'(o_draw_cnt), 16);

    // draw pile runs dry mid-draw and the discard pile is recycled
    do_reset();
    load_random(2);
    disc10.delete();
    for (int k = 0; k < 10; k++) begin
      disc10.push_back(6'($urandom));
      discard_one(disc10[k]);
    end
    chk("t4_disc_cnt", int'(o_disc_cnt), 10);
    rl0 = ready_lo;
    got_any.delete();
    draw(4, 0, 0);
    chk("t4_ready_low_cycles", ready_lo - rl0, 10);
    chk("t4_draw_cnt", int'(o_draw_cnt), 8);
    chk("t4_disc_cnt_after", int'(o_disc_cnt), 0);
    draw(4, 0, 0);
    draw(4, 0, 0);
    chk("t4_recycled_n", got_any.size(), 10);
    chk("t4_recycled_multiset", hist_diff(got_any, disc10), 0);

    // both piles empty: short pulse, no card
    do_reset();
    sc0 = short_cycles;
    vc0 = valid_cycles;
    draw(2, 0, 0);
    step();
    chk("t5_short_cycles", short_cycles - sc0, 1);
    chk("t5_no_valid", valid_cycles - vc0, 0);
    chk("t5_idle", int'(o_busy), 0);

    // reset during a shuffle, then overfill the pile
    do_reset();
    load_list(canon);
    i_shuffle = 1'b1;
    step();
    i_shuffle = 1'b0;
    repeat (5) step();
    chk("t6_busy_mid", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_draw_cnt", int'(o_draw_cnt), 0);
    chk("t6_rst_disc_cnt", int'(o_disc_cnt), 0);
    chk("t6_rst_busy", int'(o_busy), 0);
    do_reset();
    q.delete();
    for (int k = 0; k < DEPTH + 1; k++) q.push_back(6'($urandom));
    load_list(q);
    chk("t6_full_cnt", int'(o_draw_cnt), DEPTH);
    draw(1, 0, 0);
    chk("t6_after_draw", int'(o_draw_cnt), DEPTH - 1);

    // randomized mix of loads, discards and draws with simultaneous discard pushes
    do_reset();
    load_random(40);
    for (int it = 0; it < 25; it++) begin
      if (mdraw.size() < 8) load_random(10);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) discard_one(6'($urandom));
      draw(int'($urandom_range(0, 7)), 2, 1);
      chk("rand_draw_cnt", int'(o_draw_cnt), mdraw.size());
      chk("rand_disc_cnt", int'(o_disc_cnt), mdisc.size());
    end
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clear_draw_cnt", int'(o_draw_cnt), 0);
    chk("clear_disc_cnt", int'(o_disc_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
